// File: rtl/adc_sample_bank_writer.sv
// Ping-pong ADC capture: fills one bank while the reader drains the other, swapping on full.
// Optional SAMPLE_SIGN_CONV_EN stores samples with the MSB inverted (offset-binary to two's complement).
module adc_sample_bank_writer #(
    parameter int unsigned SAMPLE_W    = 8,
    parameter int unsigned SAMPLE_BITS = 9,
    parameter int unsigned NUM_SAMPLES = 512
) (
    input  logic                   sys_clk,
    input  logic                   rst,
    input  logic                   capture_en,
    input  logic                   sample_valid,
    input  logic [SAMPLE_W-1:0]    sample_data,
    input  logic                   rd_hold,
    input  logic [SAMPLE_BITS-1:0] bank_addr,
    output logic [SAMPLE_W-1:0]    bank_data,
    output logic                   bank_switch,
    output logic                   wr_bank,
    output logic                   sample_drop,
    output logic [7:0]             drop_count
);

    localparam logic [SAMPLE_BITS-1:0] LastAddr = SAMPLE_BITS'(NUM_SAMPLES - 1);

    typedef enum logic [1:0] {StIdle, StFill, StFullWait} state_e;

    state_e                  state_q, state_d;
    logic [SAMPLE_BITS-1:0]  wr_addr_q, wr_addr_d;
    logic                    wr_bank_q, wr_bank_d;
    logic                    bank_switch_q, bank_switch_d;
    logic                    sample_drop_q;
    logic [7:0]              drop_count_q, drop_count_d;
    logic [SAMPLE_W-1:0]     bank_data_q;
    logic                    we;
    logic                    drop;
    logic                    swap;
    logic [SAMPLE_W-1:0]     wr_data;

    logic [SAMPLE_W-1:0] mem [0:1][0:NUM_SAMPLES-1];

`ifdef SAMPLE_SIGN_CONV_EN
    assign wr_data = {~sample_data[SAMPLE_W-1], sample_data[SAMPLE_W-2:0]};
`else
    assign wr_data = sample_data;
`endif

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        we        = 1'b0;
        drop      = 1'b0;
        swap      = 1'b0;
        case (state_q)
            StIdle: begin
                if (capture_en) begin
                    state_d   = StFill;
                    wr_addr_d = '0;
                end
            end
            StFill: begin
                // Abort drops the partial bank; the sample in this cycle is ignored.
                if (!capture_en) begin
                    state_d   = StIdle;
                    wr_addr_d = '0;
                end else if (sample_valid) begin
                    we = 1'b1;
                    if (wr_addr_q == LastAddr) begin
                        wr_addr_d = '0;
                        if (rd_hold) begin
                            state_d = StFullWait;
                        end else begin
                            swap = 1'b1;
                        end
                    end else begin
                        wr_addr_d = wr_addr_q + 1'b1;
                    end
                end
            end
            StFullWait: begin
                if (!capture_en) begin
                    state_d   = StIdle;
                    wr_addr_d = '0;
                end else begin
                    drop = sample_valid;
                    if (!rd_hold) begin
                        swap      = 1'b1;
                        state_d   = StFill;
                        wr_addr_d = '0;
                    end
                end
            end
            default: begin
                state_d   = StIdle;
                wr_addr_d = '0;
            end
        endcase

        wr_bank_d     = swap ? ~wr_bank_q : wr_bank_q;
        bank_switch_d = swap ? ~bank_switch_q : bank_switch_q;
        drop_count_d  = (drop && drop_count_q != 8'hFF) ? drop_count_q + 8'd1 : drop_count_q;
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q       <= StIdle;
            wr_addr_q     <= '0;
            wr_bank_q     <= 1'b0;
            bank_switch_q <= 1'b0;
            sample_drop_q <= 1'b0;
            drop_count_q  <= 8'd0;
        end else begin
            state_q       <= state_d;
            wr_addr_q     <= wr_addr_d;
            wr_bank_q     <= wr_bank_d;
            bank_switch_q <= bank_switch_d;
            sample_drop_q <= drop;
            drop_count_q  <= drop_count_d;
        end
    end

    // Storage has no reset so it maps onto block RAM and survives rst.
    always_ff @(posedge sys_clk) begin
        if (we && !rst) begin
            mem[wr_bank_q][wr_addr_q] <= wr_data;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            bank_data_q <= '0;
        end else begin
            bank_data_q <= mem[~wr_bank_q][bank_addr];
        end
    end

    assign bank_data   = bank_data_q;
    assign bank_switch = bank_switch_q;
    assign wr_bank     = wr_bank_q;
    assign sample_drop = sample_drop_q;
    assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_adc_sample_bank_writer.sv
// Directed bench for adc_sample_bank_writer: fill, back-to-back, hold/drop, abort, saturation, reset.
module tb_adc_sample_bank_writer;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b1;
    logic       capture_en = 1'b0;
    logic       sample_valid = 1'b0;
    logic [7:0] sample_data = 8'h00;
    logic       rd_hold = 1'b0;
    logic [8:0] bank_addr = 9'd0;
    logic [7:0] bank_data;
    logic       bank_switch;
    logic       wr_bank;
    logic       sample_drop;
    logic [7:0] drop_count;

    int n_checks = 0;
    int n_bad    = 0;
    int n_tog    = 0;
    int n_drop   = 0;
    logic prev_bs = 1'b0;

    adc_sample_bank_writer dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .capture_en   (capture_en),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .rd_hold      (rd_hold),
        .bank_addr    (bank_addr),
        .bank_data    (bank_data),
        .bank_switch  (bank_switch),
        .wr_bank      (wr_bank),
        .sample_drop  (sample_drop),
        .drop_count   (drop_count)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [7:0] conv(input logic [7:0] d);
`ifdef SAMPLE_SIGN_CONV_EN
        return {~d[7], d[6:0]};
`else
        return d;
`endif
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then observe outputs 1ns later and track toggles/drop pulses.
    task automatic tick();
        @(posedge sys_clk);
        #1;
        if (sample_drop === 1'b1) n_drop++;
        if (bank_switch !== prev_bs) n_tog++;
        prev_bs = bank_switch;
    endtask

    task automatic push(input logic [7:0] d);
        sample_valid = 1'b1;
        sample_data  = d;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [8:0] a, input logic [7:0] exp);
        bank_addr = a;
        tick();
        check_eq(tag, {24'd0, bank_data}, {24'd0, exp});
    endtask

    task automatic clr_cnt();
        n_tog   = 0;
        n_drop  = 0;
        prev_bs = bank_switch;
    endtask

    initial begin
        // Reset state
        #2;
        tick();
        tick();
        check_eq("rst_bs", {31'd0, bank_switch}, 32'd0);
        check_eq("rst_wrbank", {31'd0, wr_bank}, 32'd0);
        check_eq("rst_dropcnt", {24'd0, drop_count}, 32'd0);
        check_eq("rst_drop", {31'd0, sample_drop}, 32'd0);
        check_eq("rst_bdata", {24'd0, bank_data}, 32'd0);
        rst = 1'b0;

        // Basic fill: data = addr[7:0]
        capture_en = 1'b1;
        tick();
        clr_cnt();
        for (int i = 0; i < 512; i++) begin
            push(8'(i));
            if (i == 510) check_eq("fill_bs_early", {31'd0, bank_switch}, 32'd0);
        end
        check_eq("fill_bs", {31'd0, bank_switch}, 32'd1);
        check_eq("fill_wrbank", {31'd0, wr_bank}, 32'd1);
        read_chk("fill_rd5", 9'd5, conv(8'h05));
        read_chk("fill_rd511", 9'd511, conv(8'hFF));

        // Back-to-back fills from reset: data = (3*i)[7:0]
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        clr_cnt();
        for (int i = 0; i < 1024; i++) push(8'(3 * i));
        check_eq("b2b_toggles", n_tog, 32'd2);
        check_eq("b2b_bs", {31'd0, bank_switch}, 32'd0);
        check_eq("b2b_wrbank", {31'd0, wr_bank}, 32'd0);
        check_eq("b2b_drops", n_drop, 32'd0);
        read_chk("b2b_rd3", 9'd3, conv(8'(3 * 515)));

        // Reader hold through the end of a bank, 10 drops, then release
        clr_cnt();
        rd_hold = 1'b1;
        for (int i = 0; i < 512; i++) push(8'(i) ^ 8'hA5);
        check_eq("hold_noswap_bank", {31'd0, wr_bank}, 32'd0);
        check_eq("hold_noswap_tog", n_tog, 32'd0);
        for (int i = 0; i < 10; i++) push(8'hEE);
        check_eq("hold_drop_pulses", n_drop, 32'd10);
        check_eq("hold_dropcnt", {24'd0, drop_count}, 32'd10);
        rd_hold = 1'b0;
        tick();
        check_eq("hold_swap_bank", {31'd0, wr_bank}, 32'd1);
        check_eq("hold_swap_bs", {31'd0, bank_switch}, 32'd1);
        check_eq("hold_drop_idle", {31'd0, sample_drop}, 32'd0);
        read_chk("hold_rd0", 9'd0, conv(8'hA5));
        read_chk("hold_rd511", 9'd511, conv(8'hFF ^ 8'hA5));

        // Abort after 100 samples, idle samples ignored, refill from address 0
        clr_cnt();
        for (int i = 0; i < 100; i++) push(8'h11);
        capture_en = 1'b0;
        push(8'h22);
        check_eq("abort_bank", {31'd0, wr_bank}, 32'd1);
        check_eq("abort_drop", {31'd0, sample_drop}, 32'd0);
        for (int i = 0; i < 3; i++) push(8'h33);
        check_eq("idle_dropcnt", {24'd0, drop_count}, 32'd10);
        check_eq("idle_drops", n_drop, 32'd0);
        check_eq("abort_tog", n_tog, 32'd0);
        capture_en = 1'b1;
        tick();
        for (int i = 0; i < 512; i++) begin
            push(8'(i) ^ 8'h3C);
            if (i == 510) check_eq("refill_bs_early", {31'd0, bank_switch}, 32'd1);
        end
        check_eq("refill_bs", {31'd0, bank_switch}, 32'd0);
        check_eq("refill_bank", {31'd0, wr_bank}, 32'd0);
        read_chk("refill_rd0", 9'd0, conv(8'h3C));
        read_chk("refill_rd99", 9'd99, conv(8'd99 ^ 8'h3C));

        // Saturation, then release with a valid sample in the same cycle
        rd_hold = 1'b1;
        for (int i = 0; i < 512; i++) push(8'(i));
        for (int i = 0; i < 300; i++) push(8'hEE);
        check_eq("sat_dropcnt", {24'd0, drop_count}, 32'd255);
        check_eq("sat_bank", {31'd0, wr_bank}, 32'd0);
        rd_hold = 1'b0;
        push(8'hEE);
        check_eq("rel_bank", {31'd0, wr_bank}, 32'd1);
        check_eq("rel_bs", {31'd0, bank_switch}, 32'd1);
        check_eq("rel_drop", {31'd0, sample_drop}, 32'd1);
        check_eq("rel_dropcnt", {24'd0, drop_count}, 32'd255);

        // Reset mid-fill (200 samples into bank 1)
        for (int i = 0; i < 200; i++) push(8'h77);
        check_eq("pre_rst_bdata", {24'd0, bank_data}, {24'd0, conv(8'd99)});
        rst = 1'b1;
        push(8'h44);
        check_eq("mid_rst_bs", {31'd0, bank_switch}, 32'd0);
        check_eq("mid_rst_bank", {31'd0, wr_bank}, 32'd0);
        check_eq("mid_rst_dropcnt", {24'd0, drop_count}, 32'd0);
        check_eq("mid_rst_drop", {31'd0, sample_drop}, 32'd0);
        check_eq("mid_rst_bdata", {24'd0, bank_data}, 32'd0);
        rst = 1'b0;
        capture_en = 1'b0;
        read_chk("mid_rst_rd0", 9'd0, conv(8'h77));
        read_chk("mid_rst_rd250", 9'd250, conv(8'd250 ^ 8'h3C));

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/adc_sample_bank_writer.md
ADC_SAMPLE_BANK_WRITER -- requirements
Module: adc_sample_bank_writer

Interface
REQ-001 Parameter SAMPLE_W, default 8: sample width in bits.
REQ-002 Parameter SAMPLE_BITS, default 9: bank address width.
REQ-003 Parameter NUM_SAMPLES, default 512: samples per bank, at most 2^SAMPLE_BITS.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 Port sys_clk, input, 1 bit: system clock; all logic is on the rising edge.
REQ-006 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 Port capture_en, input, 1 bit: enables capture of samples.
REQ-008 Port sample_valid, input, 1 bit: sample_data is valid this cycle.
REQ-009 Port sample_data, input, SAMPLE_W bits: ADC sample, offset-binary.
REQ-010 Port rd_hold, input, 1 bit: the reader is still using the read bank, so a swap is not permitted.
REQ-011 Port bank_addr, input, SAMPLE_BITS bits: read address into the read bank.
REQ-012 Port bank_data, output, SAMPLE_W bits: read data, registered.
REQ-013 Port bank_switch, output, 1 bit: toggles once per completed bank.
REQ-014 Port wr_bank, output, 1 bit: index of the bank currently being written.
REQ-015 Port sample_drop, output, 1 bit: one-cycle pulse when a valid sample is discarded.
REQ-016 Port drop_count, output, 8 bits: count of dropped samples, saturating at 255.

Function
REQ-017 Storage SHALL be two banks of NUM_SAMPLES x SAMPLE_W, inferable as EBR.
- Write bank = wr_bank.
- Read bank = ~wr_bank.
REQ-018 Read path: bank_data SHALL equal mem[~wr_bank][bank_addr] one cycle after bank_addr is presented.
- Read latency is exactly 1 cycle.
- The read bank used is the value of ~wr_bank in the cycle bank_addr is sampled.
REQ-019 FSM states SHALL be IDLE, FILL and FULL_WAIT.
REQ-020 In IDLE, when capture_en=1, the FSM SHALL go to FILL with wr_addr=0.
REQ-021 In FILL, each cycle with sample_valid=1 SHALL write one sample to mem[wr_bank][wr_addr] and increment wr_addr.
REQ-022 In FILL, a write at wr_addr=NUM_SAMPLES-1 with rd_hold=0 SHALL perform a swap in the same cycle:
- wr_bank inverts;
- wr_addr returns to 0;
- bank_switch toggles;
- the FSM stays in FILL.
REQ-023 In FILL, a write at wr_addr=NUM_SAMPLES-1 with rd_hold=1 SHALL move the FSM to FULL_WAIT with no swap.
REQ-024 In FULL_WAIT, the first cycle with rd_hold=0 SHALL perform the swap and return the FSM to FILL.
REQ-025 In FULL_WAIT, every cycle with sample_valid=1 SHALL discard the sample:
- sample_drop pulses for that cycle;
- drop_count increments, saturating at 255;
- no memory write occurs.
REQ-026 When rd_hold falls and sample_valid=1 in the same FULL_WAIT cycle, the swap SHALL occur and that sample SHALL be dropped.
REQ-027 When capture_en=0 in FILL or FULL_WAIT, the FSM SHALL go to IDLE:
- the partial bank is abandoned and wr_addr returns to 0;
- no toggle occurs and wr_bank is unchanged;
- any sample_valid in that cycle is ignored and not counted.
REQ-028 In IDLE, sample_valid SHALL be ignored and SHALL NOT be counted as dropped.
REQ-029 bank_switch SHALL toggle only on a completed bank, never on abort or reset.
REQ-030 wr_addr SHALL never exceed NUM_SAMPLES-1.

Reset
REQ-031 rst=1 SHALL set the following, taking effect at the next clock edge and overriding all other inputs:
- FSM=IDLE, wr_addr=0, wr_bank=0;
- bank_switch=0, sample_drop=0, drop_count=0, bank_data=0.
REQ-032 Memory contents SHALL NOT be cleared by reset.
REQ-033 Reset asserted mid-fill SHALL discard the fill with no bank_switch toggle.

Configuration
REQ-034 The feature is controlled by the macro SAMPLE_SIGN_CONV_EN.
- Defined: the stored sample SHALL be sample_data with its MSB inverted (offset-binary to two's complement), e.g. 8'h80 -> 8'h00 and 8'h00 -> 8'h80.
- Undefined: sample_data SHALL be stored unmodified.

Verification
REQ-035 Basic fill: rst, then capture_en=1, 512 valid samples with data = addr[7:0], rd_hold=0.
- Required: bank_switch toggles 0->1 on the cycle after the 512th sample and wr_bank=1.
- Required: reading addr 5 returns 8'h05 one cycle later (8'h85 with SAMPLE_SIGN_CONV_EN defined).
REQ-036 Back-to-back fills: 1024 continuous valid samples.
- Required: two toggles, ending with bank_switch=0 and wr_bank=0.
- Required: no sample_drop.
REQ-037 Reader hold: rd_hold=1 through the end of a bank, then 10 more valid samples, then rd_hold=0.
- Required: drop_count=10, 10 sample_drop pulses.
- Required: the swap occurs the cycle rd_hold falls.
REQ-038 Saturation: stay in FULL_WAIT and send 300 valid samples.
- Required: drop_count=255.
REQ-039 Abort: capture_en=0 after 100 samples, then 1 again.
- Required: no toggle; the next fill starts at wr_addr 0 in the same wr_bank.
REQ-040 Reset mid-fill: rst after 200 samples.
- Required: all outputs at the REQ-031 values and no toggle.
- Required: previously written bank data is still readable.
